// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the instruction memory. Receives a program image as
// a valid/ready byte stream, assembles little-endian 32-bit words and drives a
// single-cycle write port into the instruction memory. The core is held in
// reset (cpu_hold) until the whole image has been loaded.
//
// Frame: 4 length bytes (word count N, little-endian), then 4*N data bytes,
// then (checksum build only) one XOR checksum byte over all data bytes.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN - adds the trailing checksum byte and CHECK state.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid/in_data  byte stream in; in_ready is high in LEN/DATA/CHECK
//   wr_en/wr_addr/wr_data  one-cycle memory write per assembled word
//   cpu_hold          high until the load has completed successfully
//   busy              load in progress
//   done / error      sticky completion / failure flags until next start
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  // Memory depth in words; one bit wider than the length field so that an
  // address width of 32 still compares correctly.
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           asm_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic        accept;
  logic        word_done;
  logic        last_word;
  logic        load_start;
  logic [31:0] asm_next;

  assign accept     = in_valid && in_ready;
  // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0].
  assign asm_next   = {in_data, asm_q[31:8]};
  assign word_done  = accept && (byte_cnt_q == 2'd3);
  assign last_word  = (word_cnt_q + (ADDR_WIDTH+1)'(1)) == len_q;
  assign load_start = start && (state_q inside {S_IDLE, S_DONE, S_ERR});

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LEN;
      S_LEN: begin
        in_ready = 1'b1;
        if (word_done) begin
          if ({1'b0, asm_next} > DEPTH) state_d = S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else if (asm_next == 32'd0)   state_d = S_CHECK;
`else
          else if (asm_next == 32'd0)   state_d = S_DONE;
`endif
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_done && last_word) state_d = S_CHECK;
`else
        if (word_done && last_word) state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: if (start) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are decoded straight from the state register, so cpu_hold
  // drops in the same cycle as the final write strobe.
  always_comb begin
    busy     = in_ready;
    done     = (state_q == S_DONE);
    error    = (state_q == S_ERR);
    cpu_hold = (state_q != S_DONE);
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      // The address advances in the cycle after each write; after the last
      // word of a full-depth image it wraps to 0 and is never used.
      if (wr_en_q) wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);

      if (load_start) begin
        // Later assignment wins over the increment above: a restart always
        // begins writing at address 0.
        byte_cnt_q <= '0;
        len_q      <= '0;
        word_cnt_q <= '0;
        wr_addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end else if (accept && (state_q == S_LEN || state_q == S_DATA)) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        asm_q      <= asm_next;
        if (state_q == S_LEN) begin
          // Only meaningful when the length is in range; otherwise ERR.
          if (word_done) len_q <= asm_next[ADDR_WIDTH:0];
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ in_data;
`endif
          if (word_done) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= asm_next;
            word_cnt_q <= word_cnt_q + (ADDR_WIDTH+1)'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed testbench for imem_loader (ADDR_WIDTH = 8). Streams hand-built
// frames, records every write strobe seen on the memory port and compares
// writes and status flags with hand-computed values. Honours
// IMEM_LOADER_CHECKSUM_EN to append the checksum byte where the frame needs it.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  // Write log filled by the monitor; exp_csum is the bench's own XOR model.
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    exp_csum;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got = 1'b0;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit is_data);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      if (is_data) exp_csum = exp_csum ^ b;
      send_byte(b, gap);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_csum = 8'h00;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"}, wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check({tag, "_a0"}, wa_q[0], 0);
      check({tag, "_d0"}, wd_q[0], 32'h0000_0013);
      check({tag, "_a1"}, wa_q[1], 1);
      check({tag, "_d1"}, wd_q[1], 32'h0010_0093);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_err"}, error, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int errs;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_csum = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_ready", in_ready, 0);
    check("rst_wren", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    rst_n = 1'b1;

    // Basic two-word load, 1 byte/cycle
    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    check("start_hold", cpu_hold, 1);
    send_word(32'd2, 1'b0, 1'b0);
    send_word(32'h0000_0013, 1'b0, 1'b1);
    send_word(32'h0010_0093, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("csum_model", exp_csum, 32'h90);
    send_byte(exp_csum, 1'b0);
`else
    // Final write strobe coincides with DONE and the release of cpu_hold.
    @(negedge clk);
    check("last_wr_en", wr_en, 1);
    check("last_wr_done", done, 1);
    check("last_wr_hold", cpu_hold, 0);
`endif
    idle(2);
    check_two_word("basic");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, then ERR
    pulse_start();
    send_word(32'd2, 1'b0, 1'b0);
    send_word(32'h0000_0013, 1'b0, 1'b1);
    send_word(32'h0010_0093, 1'b0, 1'b1);
    send_byte(8'h91, 1'b0);
    idle(2);
    check("badck_nwr", wa_q.size(), 2);
    check("badck_err", error, 1);
    check("badck_done", done, 0);
    check("badck_hold", cpu_hold, 1);
    check("badck_ready", in_ready, 0);
`endif

    // Restart from DONE/ERR with oversize length 0x101
    pulse_start();
    check("restart_done", done, 0);
    check("restart_hold", cpu_hold, 1);
    send_word(32'h0000_0101, 1'b0, 1'b0);
    idle(2);
    check("ovf_err", error, 1);
    check("ovf_done", done, 0);
    check("ovf_ready", in_ready, 0);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_nwr", wa_q.size(), 0);

    // Zero-length frame
    pulse_start();
    check("zero_err_clr", error, 0);
    send_word(32'd0, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    idle(2);
    check("zero_done", done, 1);
    check("zero_hold", cpu_hold, 0);
    check("zero_nwr", wa_q.size(), 0);

    // in_valid toggling every cycle, start pulsed mid-DATA (ignored)
    pulse_start();
    send_word(32'd2, 1'b1, 1'b0);
    send_word(32'h0000_0013, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("midstart_busy", busy, 1);
    send_word(32'h0010_0093, 1'b1, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 1'b1);
`endif
    idle(2);
    check_two_word("toggle");

    // Reset mid-DATA, then a clean reload from address 0
    pulse_start();
    send_word(32'd2, 1'b0, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_hold", cpu_hold, 1);
    check("mrst_ready", in_ready, 0);
    check("mrst_addr", wr_addr, 0);
    check("mrst_done", done, 0);
    check("mrst_wren", wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_word(32'd2, 1'b0, 1'b0);
    send_word(32'h0000_0013, 1'b0, 1'b1);
    send_word(32'h0010_0093, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 1'b0);
`endif
    idle(2);
    check_two_word("reload");

    // Full-depth image N = 256 is legal; wr_addr wraps to 0 afterwards
    pulse_start();
    send_word(32'd256, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_word({8'(i), ~8'(i), 8'h3C, 8'(i + 1)}, 1'b0, 1'b1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 1'b0);
`endif
    idle(2);
    check("full_nwr", wa_q.size(), 256);
    errs = 0;
    if (wa_q.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        if (wa_q[i] !== 8'(i) || wd_q[i] !== {8'(i), ~8'(i), 8'h3C, 8'(i + 1)}) errs++;
      end
    end
    check("full_words", errs, 0);
    check("full_done", done, 1);
    check("full_wrap", wr_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory.
- Receives a program image as a byte stream with a valid/ready handshake, assembles the bytes into 32-bit little-endian words, and drives a single-cycle write port into the instruction memory array.
- Holds the core in reset via cpu_hold until the image is loaded (and, when enabled, checksum-verified).

Parameters:
- ADDR_WIDTH, 8, word-address width; memory depth = 2**ADDR_WIDTH words (256 = 1 KB).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction memory write strobe, one cycle per word
- wr_addr  output  ADDR_WIDTH  word index being written
- wr_data  output  32  assembled instruction word
- cpu_hold  output  1  keep core in reset while high
- busy  output  1  load in progress
- done  output  1  sticky; load completed successfully
- error  output  1  sticky; length overflow or checksum mismatch

Behaviour:
- Byte accepted = in_valid & in_ready at a rising clk edge. in_ready is combinational from state: 1 in LEN/DATA/CHECK, 0 otherwise.
- Frame format: 4 length bytes (word count N, little-endian 32-bit), then 4*N data bytes (each word little-endian), then 1 checksum byte (only with the optional feature).
- Reset (async, rst_n=0):
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=1, busy=0, done=0, error=0.
  - Byte counter, word counter, length and checksum accumulator cleared.
  - Reset mid-load abandons the frame; memory contents already written are not undone.
- IDLE: start -> LEN; clear done/error; busy=1.
- LEN: collects 4 bytes. After the 4th:
  - N > 2**ADDR_WIDTH -> ERR.
  - N = 0 -> CHECK (feature on) or DONE (feature off).
  - Otherwise -> DATA.
- DATA:
  - Byte k of a word goes to bits [8k+7:8k].
  - On acceptance of the 4th byte, wr_en=1 on the next cycle for exactly one cycle, with wr_data = the full word and wr_addr = current word index.
  - wr_addr increments by 1 in the cycle after each write. The first write is to address 0.
  - After word N-1 is accepted -> CHECK (feature on) or DONE.
  - in_ready stays 1 during the write cycle; memory never back-pressures.
  - A back-to-back word is sustained at 1 byte/cycle.
- CHECK: accept 1 byte, compare with the checksum accumulator. Equal -> DONE, else -> ERR.
- DONE: done=1, busy=0, cpu_hold=0.
- ERR: error=1, busy=0, cpu_hold stays 1.
- start in DONE/ERR: restart -> LEN; done/error cleared; cpu_hold reasserted to 1 in the same edge.
- start in LEN/DATA/CHECK: ignored.
- The final wr_en pulse happens in the same cycle the state becomes DONE. cpu_hold falls together with it; the write completes before the core leaves reset.
- N = 2**ADDR_WIDTH is legal. wr_addr wraps to 0 after the last write; that wrapped value is unused.
- in_valid while in_ready=0: byte not consumed, no effect.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The frame carries a trailing checksum byte, equal to the 8-bit XOR of all 4*N data bytes. Length bytes are excluded.
  - The CHECK state exists; a mismatch -> ERR. Words already written remain in memory.
- Undefined:
  - No checksum byte, no CHECK state, no accumulator logic.
  - The last data word (or N=0) goes directly to DONE.

Test Plan:
- Reset, start, stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00 [| 90] -> wr_en pulses at addr 0 data 0x00000013 and addr 1 data 0x00100093; done=1, cpu_hold=0, error=0.
- With feature on, same frame but checksum 0x91 -> both writes occur, then error=1, done=0, cpu_hold=1, in_ready=0.
- Length 0x00000101 with ADDR_WIDTH=8 -> ERR after the 4th length byte, no wr_en, in_ready=0.
- Length 0 -> zero writes; DONE directly (feature off) or after checksum byte 0x00 (feature on).
- in_valid toggled 1/0 every cycle during the 2-word frame -> identical writes and result. start pulsed mid-DATA -> ignored.
- Assert rst_n=0 mid-DATA -> all outputs at reset values immediately. A new start with a full frame then loads correctly from address 0.
